// File: rtl/wb_stage_pkg.sv
// Shared MIPS opcode/funct constants and the destination/write-data decode,
// reused by the decode-stage controller and the write-back stage.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [2:0] {LD_NONE, LD_W, LD_B, LD_BU, LD_H, LD_HU} load_t;
  typedef enum logic [1:0] {SEL_ALU, SEL_PC8, SEL_LOAD} wsel_t;

  typedef struct packed {
    logic       writes;
    logic [4:0] dest;
    wsel_t      sel;
    load_t      ld;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [5:0] fn);
    dec_t d;
    d = '{writes: 1'b0, dest: 5'd0, sel: SEL_ALU, ld: LD_NONE};
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: begin
            d.writes = 1'b1;
            d.dest   = rd;
          end
          FN_JALR: begin
            d.writes = 1'b1;
            d.dest   = rd;
            d.sel    = SEL_PC8;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ADDIU, OP_LUI: begin
        d.writes = 1'b1;
        d.dest   = rt;
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        d.writes = 1'b1;
        d.dest   = rt;
        d.sel    = SEL_LOAD;
        case (op)
          OP_LB:   d.ld = LD_B;
          OP_LBU:  d.ld = LD_BU;
          OP_LH:   d.ld = LD_H;
          OP_LHU:  d.ld = LD_HU;
          default: d.ld = LD_W;
        endcase
      end
      OP_JAL: begin
        d.writes = 1'b1;
        d.dest   = REG_RA;
        d.sel    = SEL_PC8;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Memory-to-writeback bus: M-stage inputs and the register-file write port.
interface wb_stage_if #(parameter int CNT_W = 32);
  logic             stall_W;
  logic             flush_W;
  logic [31:0]      IR_M;
  logic [31:0]      PC8_M;
  logic [31:0]      AO_M;
  logic [31:0]      M_RD;
  logic [31:0]      IR_W;
  logic             RegWrite;
  logic [4:0]       RegAddr;
  logic [31:0]      RegData;
  logic [31:0]      PC8_W2D;
  logic [CNT_W-1:0] retired;

  modport master (
    output stall_W, flush_W, IR_M, PC8_M, AO_M, M_RD,
    input  IR_W, RegWrite, RegAddr, RegData, PC8_W2D, retired
  );

  modport slave (
    input  stall_W, flush_W, IR_M, PC8_M, AO_M, M_RD,
    output IR_W, RegWrite, RegAddr, RegData, PC8_W2D, retired
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Picks the addressed byte/halfword out of a word-aligned load and extends it.
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] i_dr,
  input  logic [1:0]  i_ao_lo,
  input  load_t       i_ld,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_dr[7:0];
    case (i_ao_lo)
      2'd1:    w_byte = i_dr[15:8];
      2'd2:    w_byte = i_dr[23:16];
      2'd3:    w_byte = i_dr[31:24];
      default: w_byte = i_dr[7:0];
    endcase
    // Halfword alignment comes from bit 1 only; a misaligned bit 0 is ignored.
    w_half = i_ao_lo[1] ? i_dr[31:16] : i_dr[15:0];
  end

  always_comb begin
    o_data = i_dr;
    case (i_ld)
      LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_data = {24'd0, w_byte};
      LD_H:    o_data = {{16{w_half[15]}}, w_half};
      LD_HU:   o_data = {16'd0, w_half};
      default: o_data = i_dr;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: M/W pipeline register, destination decode, write-data
// select and a retired-instruction counter.
module wb_stage
  import mips_defs::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave bus
);

  logic [31:0]      r_ir;
  logic [31:0]      r_pc8;
  logic [31:0]      r_ao;
  logic [31:0]      r_dr;
  logic             r_valid;
  logic [CNT_W-1:0] r_retired;

  dec_t        w_dec;
  logic        w_reg_write;
  logic [31:0] w_ld_data;
  logic [31:0] w_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir      <= 32'd0;
      r_pc8     <= RESET_PC8;
      r_ao      <= 32'd0;
      r_dr      <= 32'd0;
      r_valid   <= 1'b0;
      r_retired <= '0;
    end else begin
      // The instruction in W retires as it leaves, which a stall prevents.
      if (r_valid && !bus.stall_W)
        r_retired <= r_retired + CNT_W'(1);
      if (bus.flush_W) begin
        r_ir    <= 32'd0;
        r_ao    <= 32'd0;
        r_dr    <= 32'd0;
        r_valid <= 1'b0;
      end else if (!bus.stall_W) begin
        r_ir    <= bus.IR_M;
        r_pc8   <= bus.PC8_M;
        r_ao    <= bus.AO_M;
        r_dr    <= bus.M_RD;
        r_valid <= (bus.IR_M != 32'd0);
      end
    end
  end

  assign w_dec       = decode(r_ir[31:26], r_ir[20:16], r_ir[15:11], r_ir[5:0]);
  assign w_reg_write = r_valid && w_dec.writes && (w_dec.dest != 5'd0);

  load_ext u_load_ext (
    .i_dr    (r_dr),
    .i_ao_lo (r_ao[1:0]),
    .i_ld    (w_dec.ld),
    .o_data  (w_ld_data)
  );

  always_comb begin
    w_data = r_ao;
    case (w_dec.sel)
      SEL_PC8:  w_data = r_pc8;
      SEL_LOAD: w_data = w_ld_data;
      default:  w_data = r_ao;
    endcase
  end

  assign bus.IR_W     = r_ir;
  assign bus.PC8_W2D  = r_pc8;
  assign bus.retired  = r_retired;
  assign bus.RegWrite = w_reg_write;
  assign bus.RegAddr  = w_reg_write ? w_dec.dest : 5'd0;
  assign bus.RegData  = w_reg_write ? w_data : 32'd0;

endmodule
